// File: rtl/calc_key_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : calc_key_sequencer
//  Purpose  : Keypad entry sequencer for the calculator. Builds two BCD
//             operands and an operator, ships them as a byte frame and
//             collects the 16-bit reply from the remote side.
//  Revision : 1.0  initial release
// ============================================================================
module calc_key_sequencer #(
  parameter int DIGITS  = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  keyCode,
  input  logic        keyValid,
  output logic [3:0]  num,
  output logic        numPressed,
  output logic        clear,
  output logic        submit,
  output logic [7:0]  txData,
  output logic        txValid,
  input  logic        txReady,
  input  logic [7:0]  rxData,
  input  logic        rxValid,
  output logic [15:0] result,
  output logic        resultValid,
  output logic        busy,
  output logic        error
);

  localparam int c_OPW = 4 * DIGITS;
  localparam int c_CW  = $clog2(DIGITS + 1);
  localparam int c_IW  = $clog2(DIGITS + 2);
  localparam int c_TW  = $clog2(TIMEOUT + 1);
  localparam logic [c_CW-1:0] c_CNT_MAX  = c_CW'(DIGITS);
  localparam logic [c_IW-1:0] c_IDX_LAST = c_IW'(DIGITS);
  localparam logic [c_TW-1:0] c_TMO      = c_TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_OP1  = 3'd0,
    S_OP2  = 3'd1,
    S_SEND = 3'd2,
    S_WAIT = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t            r_state;
  logic [c_OPW-1:0]  r_op1;
  logic [c_OPW-1:0]  r_op2;
  logic [c_CW-1:0]   r_cnt1;
  logic [c_CW-1:0]   r_cnt2;
  logic [3:0]        r_opcode;
  logic [c_IW-1:0]   r_idx;
  logic [c_TW-1:0]   r_timer;
  logic              r_rxHalf;
  logic [7:0]        r_rxHi;

  logic              w_isDigit;
  logic              w_isOp;
  logic              w_isEq;
  logic              w_isClr;
  logic [c_IW-1:0]   w_selIdx;
  logic [7:0]        w_opAscii;
  logic [7:0]        w_nextByte;

  assign w_isDigit = keyValid && (keyCode <= 4'd9);
  assign w_isOp    = keyValid && (keyCode >= 4'd10) && (keyCode <= 4'd13);
  assign w_isEq    = keyValid && (keyCode == 4'd14);
  assign w_isClr   = keyValid && (keyCode == 4'd15);

  // Byte to present next: index 0 when launching a frame, idx+1 on each acceptance.
  assign w_selIdx = (r_state == S_SEND) ? (r_idx + c_IW'(1)) : '0;

  always_comb begin
    w_opAscii = 8'h2B;
    case (r_opcode)
      4'd11:   w_opAscii = 8'h2D;
      4'd12:   w_opAscii = 8'h2A;
      4'd13:   w_opAscii = 8'h2F;
      default: w_opAscii = 8'h2B;
    endcase
  end

  always_comb begin
    w_nextByte = w_opAscii;
    for (int i = 0; i < DIGITS / 2; i++) begin
      if (w_selIdx == c_IW'(i))
        w_nextByte = r_op1[c_OPW-1-8*i -: 8];
      if (w_selIdx == c_IW'(i + DIGITS / 2 + 1))
        w_nextByte = r_op2[c_OPW-1-8*i -: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_OP1;
      r_op1       <= '0;
      r_op2       <= '0;
      r_cnt1      <= '0;
      r_cnt2      <= '0;
      r_opcode    <= '0;
      r_idx       <= '0;
      r_timer     <= '0;
      r_rxHalf    <= 1'b0;
      r_rxHi      <= '0;
      num         <= '0;
      numPressed  <= 1'b0;
      clear       <= 1'b0;
      submit      <= 1'b0;
      txData      <= '0;
      txValid     <= 1'b0;
      result      <= '0;
      resultValid <= 1'b0;
      busy        <= 1'b0;
      error       <= 1'b0;
    end else begin
      numPressed  <= 1'b0;
      clear       <= 1'b0;
      submit      <= 1'b0;
      resultValid <= 1'b0;
      case (r_state)
        S_OP1: begin
          if (w_isClr) begin
            r_op1  <= '0;
            r_op2  <= '0;
            r_cnt1 <= '0;
            r_cnt2 <= '0;
            error  <= 1'b0;
            clear  <= 1'b1;
          end else if (w_isDigit) begin
            if (r_cnt1 < c_CNT_MAX) begin
              r_op1      <= {r_op1[c_OPW-5:0], keyCode};
              r_cnt1     <= r_cnt1 + c_CW'(1);
              num        <= keyCode;
              numPressed <= 1'b1;
            end
          end else if (w_isOp && (r_cnt1 != '0)) begin
            r_opcode <= keyCode;
            clear    <= 1'b1;
            r_state  <= S_OP2;
          end
        end
        S_OP2: begin
          if (w_isClr) begin
            r_op1    <= '0;
            r_op2    <= '0;
            r_cnt1   <= '0;
            r_cnt2   <= '0;
            r_opcode <= '0;
            clear    <= 1'b1;
            r_state  <= S_OP1;
          end else if (w_isDigit) begin
            if (r_cnt2 < c_CNT_MAX) begin
              r_op2      <= {r_op2[c_OPW-5:0], keyCode};
              r_cnt2     <= r_cnt2 + c_CW'(1);
              num        <= keyCode;
              numPressed <= 1'b1;
            end
          end else if (w_isEq && (r_cnt2 != '0)) begin
            submit  <= 1'b1;
            r_idx   <= '0;
            txData  <= w_nextByte;
            txValid <= 1'b1;
            busy    <= 1'b1;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (txReady) begin
            if (r_idx == c_IDX_LAST) begin
              txValid  <= 1'b0;
              r_timer  <= c_TMO;
              r_rxHalf <= 1'b0;
              r_state  <= S_WAIT;
            end else begin
              r_idx  <= r_idx + c_IW'(1);
              txData <= w_nextByte;
            end
          end
        end
        S_WAIT: begin
          // An abort key takes priority over a byte arriving in the same cycle.
          if (w_isClr) begin
            r_op1   <= '0;
            r_op2   <= '0;
            r_cnt1  <= '0;
            r_cnt2  <= '0;
            clear   <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_OP1;
          end else if (rxValid) begin
            if (!r_rxHalf) begin
              r_rxHi   <= rxData;
              r_rxHalf <= 1'b1;
            end else begin
              result      <= {r_rxHi, rxData};
              resultValid <= 1'b1;
              r_op1       <= '0;
              r_op2       <= '0;
              r_cnt1      <= '0;
              r_cnt2      <= '0;
              busy        <= 1'b0;
              r_state     <= S_OP1;
            end
          end else if (r_timer == '0) begin
            error   <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_ERR;
          end else begin
            r_timer <= r_timer - c_TW'(1);
          end
        end
        S_ERR: begin
          if (w_isClr) begin
            r_op1   <= '0;
            r_op2   <= '0;
            r_cnt1  <= '0;
            r_cnt2  <= '0;
            error   <= 1'b0;
            clear   <= 1'b1;
            r_state <= S_OP1;
          end
        end
        default: r_state <= S_OP1;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_calc_key_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_calc_key_sequencer
//  Purpose  : Scoreboard bench for calc_key_sequencer with directed key/link
//             vectors and hand-computed expected strobes, frames and results.
//  Revision : 1.0  initial release
// ============================================================================
module tb_calc_key_sequencer;

  localparam int DIGITS  = 4;
  localparam int TIMEOUT = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  keyCode;
  logic        keyValid;
  logic [3:0]  num;
  logic        numPressed;
  logic        clear;
  logic        submit;
  logic [7:0]  txData;
  logic        txValid;
  logic        txReady;
  logic [7:0]  rxData;
  logic        rxValid;
  logic [15:0] result;
  logic        resultValid;
  logic        busy;
  logic        error;

  calc_key_sequencer #(.DIGITS(DIGITS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .keyCode(keyCode), .keyValid(keyValid),
    .num(num), .numPressed(numPressed), .clear(clear), .submit(submit),
    .txData(txData), .txValid(txValid), .txReady(txReady),
    .rxData(rxData), .rxValid(rxValid), .result(result),
    .resultValid(resultValid), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  // Strobe encoding: {kind, digit}; kind 1=numPressed, 2=clear, 3=submit.
  logic [5:0]  exp_str[$];
  logic [7:0]  exp_tx[$];
  logic [15:0] exp_res[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [5:0] got_s;
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = '0;

  always @(negedge clk) begin
    if (!reset) begin
      if (numPressed || clear || submit) begin
        chk("strobe_exclusive", 64'(int'(numPressed) + int'(clear) + int'(submit)), 64'd1);
        got_s = numPressed ? {2'd1, num} : (clear ? 6'h20 : 6'h30);
        if (exp_str.size() == 0) chk("strobe_unexpected", 64'(got_s), 64'h0);
        else chk("strobe", 64'(got_s), 64'(exp_str.pop_front()));
      end
      if (txValid && txReady) begin
        if (exp_tx.size() == 0) chk("tx_unexpected", 64'(txData), 64'h100);
        else chk("tx_byte", 64'(txData), 64'(exp_tx.pop_front()));
      end
      if (stall_prev) chk("tx_stable", 64'({txValid, txData}), 64'({1'b1, stall_data}));
      stall_prev = txValid && !txReady;
      stall_data = txData;
      if (resultValid) begin
        if (exp_res.size() == 0) chk("result_unexpected", 64'(result), 64'h10000);
        else chk("result", 64'(result), 64'(exp_res.pop_front()));
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic key(input logic [3:0] k);
    @(posedge clk); #1;
    keyCode = k; keyValid = 1'b1;
    @(posedge clk); #1;
    keyValid = 1'b0;
  endtask

  task automatic rx(input logic [7:0] d);
    @(posedge clk); #1;
    rxData = d; rxValid = 1'b1;
    @(posedge clk); #1;
    rxValid = 1'b0;
  endtask

  task automatic digits(input logic [3:0] d);
    exp_str.push_back({2'd1, d});
    key(d);
  endtask

  task automatic push_tx(input logic [39:0] f);
    for (int i = 4; i >= 0; i--) exp_tx.push_back(f[8*i +: 8]);
  endtask

  // Wait until the frame has been fully sent and the DUT sits waiting for a reply.
  task automatic wait_reply_phase(input string name);
    int n;
    n = 0;
    while (!(busy && !txValid) && n < 60) begin
      @(negedge clk); n++;
    end
    chk(name, 64'(busy && !txValid), 64'd1);
  endtask

  initial begin
    int n;
    reset = 1'b1; keyCode = '0; keyValid = 1'b0; txReady = 1'b0;
    rxData = '0; rxValid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {num, numPressed, clear, submit, txData, txValid,
                          result, resultValid, busy, error}, 64'h0);

    // Reset in the middle of a frame after two accepted bytes.
    digits(4'd5);
    exp_str.push_back(6'h20); key(4'd10);
    digits(4'd6);
    exp_str.push_back(6'h30); key(4'd14);
    push_tx(40'h00_05_2B_00_06);
    void'(exp_tx.pop_back()); void'(exp_tx.pop_back()); void'(exp_tx.pop_back());
    txReady = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    txReady = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midframe_reset_outputs", {num, numPressed, clear, submit, txData, txValid,
                                   result, resultValid, busy, error}, 64'h0);

    // Basic entry 12+3= with the transmitter always ready.
    txReady = 1'b1;
    digits(4'd1); digits(4'd2);
    exp_str.push_back(6'h20); key(4'd10);
    digits(4'd3);
    exp_str.push_back(6'h30); push_tx(40'h00_12_2B_00_03); key(4'd14);
    wait_reply_phase("wait_after_frame1");
    chk("busy_in_wait", 64'(busy), 64'd1);
    rx(8'h00);
    exp_res.push_back(16'h000F);
    rx(8'h0F);
    @(negedge clk);
    @(negedge clk);
    chk("result_pulse_width", 64'(resultValid), 64'd0);
    chk("result_hold", 64'(result), 64'h000F);
    chk("busy_after_result", 64'(busy), 64'd0);

    // Ignored keys, operand overflow, and a 5-cycle stall on byte 1.
    txReady = 1'b0;
    key(4'd12);
    key(4'd14);
    digits(4'd9); digits(4'd8); digits(4'd7); digits(4'd6);
    key(4'd5);
    exp_str.push_back(6'h20); key(4'd13);
    digits(4'd7);
    exp_str.push_back(6'h30); push_tx(40'h98_76_2F_00_07); key(4'd14);
    txReady = 1'b1;
    @(posedge clk); #1;
    txReady = 1'b0;
    repeat (5) @(posedge clk);
    #1 txReady = 1'b1;
    wait_reply_phase("wait_after_frame2");

    // No reply: timeout, ignored traffic in the error state, then recovery.
    n = 0;
    while (!error && n < 100) begin
      @(negedge clk); n++;
    end
    chk("timeout_error", 64'(error), 64'd1);
    chk("timeout_window", 64'(n >= TIMEOUT && n <= TIMEOUT + 2), 64'd1);
    chk("busy_in_err", 64'(busy), 64'd0);
    rx(8'h55); rx(8'h66);
    key(4'd3);
    exp_str.push_back(6'h20); key(4'd15);
    @(negedge clk);
    chk("error_cleared", 64'(error), 64'd0);

    digits(4'd4);
    exp_str.push_back(6'h20); key(4'd11);
    digits(4'd1);
    exp_str.push_back(6'h30); push_tx(40'h00_04_2D_00_01); key(4'd14);
    wait_reply_phase("wait_after_frame3");

    // Abort with a byte arriving in the same cycle; later bytes are ignored.
    rx(8'h12);
    @(posedge clk); #1;
    keyCode = 4'd15; keyValid = 1'b1; rxData = 8'h34; rxValid = 1'b1;
    exp_str.push_back(6'h20);
    @(posedge clk); #1;
    keyValid = 1'b0; rxValid = 1'b0;
    rx(8'h56);
    @(negedge clk);
    chk("result_after_abort", 64'(result), 64'h000F);
    chk("busy_after_abort", 64'(busy), 64'd0);

    repeat (4) @(negedge clk);
    chk("strobe_queue_drained", 64'(exp_str.size()), 64'd0);
    chk("tx_queue_drained", 64'(exp_tx.size()), 64'd0);
    chk("result_queue_drained", 64'(exp_res.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
